// File: rtl/ws2812_framebuf.sv
// Double-buffered pixel store feeding the ws2812c driver: pattern logic fills the back
// bank, and a commit swaps banks at the next frame start; reads are brightness-scaled.
module ws2812_framebuf #(
  parameter int NUM_LEDS  = 8,
  parameter int ADDR_BITS = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [23:0]          wr_rgb,
  output logic                 wr_ready,
  input  logic                 commit,
  input  logic [7:0]           scale,
  input  logic [ADDR_BITS-1:0] address,
  input  logic                 new_address,
  output logic [7:0]           red,
  output logic [7:0]           green,
  output logic [7:0]           blue,
  output logic                 pending
);

  localparam int                 Depth   = 2 << ADDR_BITS;
  localparam logic [ADDR_BITS:0] NumLeds = NUM_LEDS[ADDR_BITS:0];

  logic frontSel_q, frontSel_d;
  logic pending_q, pending_d;
  logic shownValid_q, shownValid_d;
  logic frameStart, swap, wrAccept, rdInRange;

  logic [23:0] mem [Depth];
  logic [23:0] rdData_q;
  logic [7:0]  fetchScale_q;
  logic        fetchZero_q, fetchValid_q;
  logic [7:0]  red_q, green_q, blue_q;

  // 9-bit factor (scale+1) so that 255 is an exact identity after dropping 8 bits.
  function automatic logic [7:0] scaleChan(input logic [7:0] c, input logic [7:0] s);
    logic [16:0] prod;
    prod = {9'd0, c} * ({9'd0, s} + 17'd1);
    return 8'(prod >> 8);
  endfunction

  always_comb begin
    frameStart   = new_address && (address == '0);
    swap         = frameStart && (pending_q || commit);
    wrAccept     = wr_en && !pending_q && ({1'b0, wr_addr} < NumLeds);
    rdInRange    = ({1'b0, address} < NumLeds);
    frontSel_d   = frontSel_q;
    pending_d    = pending_q;
    shownValid_d = shownValid_q;
    if (swap) begin
      frontSel_d   = ~frontSel_q;
      pending_d    = 1'b0;
      shownValid_d = 1'b1;
    end else if (commit) begin
      pending_d = 1'b1;
    end
  end

  // The fetch indexes with the next-state bank select so a swapping frame start
  // already reads the new front bank; a same-edge write to that pixel is not seen.
  always_ff @(posedge clk) begin
    if (wrAccept) mem[{~frontSel_q, wr_addr}] <= wr_rgb;
    if (new_address) rdData_q <= mem[{frontSel_d, address}];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frontSel_q   <= 1'b0;
      pending_q    <= 1'b0;
      shownValid_q <= 1'b0;
      fetchValid_q <= 1'b0;
      fetchZero_q  <= 1'b1;
      fetchScale_q <= 8'd0;
      red_q        <= 8'd0;
      green_q      <= 8'd0;
      blue_q       <= 8'd0;
    end else begin
      frontSel_q   <= frontSel_d;
      pending_q    <= pending_d;
      shownValid_q <= shownValid_d;
      fetchValid_q <= new_address;
      if (new_address) begin
        fetchScale_q <= scale;
        fetchZero_q  <= !shownValid_d || !rdInRange;
      end
      if (fetchValid_q) begin
        if (fetchZero_q) begin
          red_q   <= 8'd0;
          green_q <= 8'd0;
          blue_q  <= 8'd0;
        end else begin
          red_q   <= scaleChan(rdData_q[23:16], fetchScale_q);
          green_q <= scaleChan(rdData_q[15:8], fetchScale_q);
          blue_q  <= scaleChan(rdData_q[7:0], fetchScale_q);
        end
      end
    end
  end

  assign wr_ready = ~pending_q;
  assign pending  = pending_q;
  assign red      = red_q;
  assign green    = green_q;
  assign blue     = blue_q;

endmodule

// File: tb/tb_ws2812_framebuf.sv
// Scoreboard bench for ws2812_framebuf: fetches push hand-computed pixels into a queue,
// and a monitor compares outputs two edges after each sampled new_address.
module tb_ws2812_framebuf;

  localparam int NumLeds  = 8;
  localparam int AddrBits = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          wr_en = 1'b0;
  logic [3:0]    wr_addr = 4'd0;
  logic [23:0]   wr_rgb = 24'd0;
  logic          wr_ready;
  logic          commit = 1'b0;
  logic [7:0]    scale = 8'd255;
  logic [3:0]    address = 4'd0;
  logic          new_address = 1'b0;
  logic [7:0]    red, green, blue;
  logic          pending;

  typedef struct packed {
    logic [3:0]  addr;
    logic [23:0] rgb;
  } expT;

  expT        expQ[$];
  int         errors = 0;
  int         checks = 0;
  logic [1:0] reqHist = 2'b00;

  ws2812_framebuf #(.NUM_LEDS(NumLeds), .ADDR_BITS(AddrBits)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_rgb(wr_rgb),
    .wr_ready(wr_ready), .commit(commit), .scale(scale), .address(address),
    .new_address(new_address), .red(red), .green(green), .blue(blue), .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [23:0] act, input logic [23:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [3:0] wa, input logic [23:0] wd,
                               input logic cm, input logic na, input logic [3:0] ad);
    @(negedge clk);
    wr_en = we;
    wr_addr = wa;
    wr_rgb = wd;
    commit = cm;
    new_address = na;
    address = ad;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 4'd0, 24'd0, 1'b0, 1'b0, 4'd0);
  endtask

  task automatic writePix(input logic [3:0] a, input logic [23:0] d);
    applyStimulus(1'b1, a, d, 1'b0, 1'b0, 4'd0);
  endtask

  task automatic fetch(input logic [3:0] a, input logic [23:0] exp);
    expQ.push_back('{addr: a, rgb: exp});
    applyStimulus(1'b0, 4'd0, 24'd0, 1'b0, 1'b1, a);
    idle(3);
  endtask

  task automatic doCommit();
    applyStimulus(1'b0, 4'd0, 24'd0, 1'b1, 1'b0, 4'd0);
    idle(1);
  endtask

  // Monitor: a request sampled at one edge is due on the output after the following edge.
  initial begin
    expT e;
    forever begin
      @(posedge clk);
      reqHist = {reqHist[0], new_address};
      #1;
      if (reqHist[1]) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_fetch: got 0x%0h, expected no request", {red, green, blue});
        end else begin
          e = expQ.pop_front();
          checkOutput($sformatf("pix%0d", e.addr), {red, green, blue}, e.rgb);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [23:0] initPix [8];
    initPix = '{24'hFF8000, 24'h0A0B0C, 24'h112233, 24'h000000,
                24'h000000, 24'h000000, 24'h000000, 24'h000000};

    // Reset and empty display
    #1 reset = 1'b0;
    #2;
    checkOutput("reset_rgb", {red, green, blue}, 24'h0);
    checkOutput("reset_pending", {23'd0, pending}, 24'd0);
    checkOutput("reset_wr_ready", {23'd0, wr_ready}, 24'd1);
    idle(2);
    reset = 1'b1;
    idle(1);
    for (int i = 0; i < NumLeds; i++) fetch(4'(i), 24'h000000);
    checkOutput("t1_wr_ready", {23'd0, wr_ready}, 24'd1);
    checkOutput("t1_pending", {23'd0, pending}, 24'd0);

    // Fill back bank, commit, swap at frame start
    for (int i = 0; i < NumLeds; i++) writePix(4'(i), initPix[i]);
    doCommit();
    checkOutput("t2_pending", {23'd0, pending}, 24'd1);
    checkOutput("t2_wr_ready", {23'd0, wr_ready}, 24'd0);
    fetch(4'd3, 24'h000000);
    checkOutput("t2_pending_hold", {23'd0, pending}, 24'd1);
    fetch(4'd0, 24'hFF8000);
    checkOutput("t2_pending_clr", {23'd0, pending}, 24'd0);
    fetch(4'd2, 24'h112233);
    fetch(4'd1, 24'h0A0B0C);
    fetch(4'd5, 24'h000000);
    expQ.push_back('{addr: 4'd2, rgb: 24'h112233});
    applyStimulus(1'b0, 4'd0, 24'd0, 1'b0, 1'b1, 4'd2);
    expQ.push_back('{addr: 4'd1, rgb: 24'h0A0B0C});
    applyStimulus(1'b0, 4'd0, 24'd0, 1'b0, 1'b1, 4'd1);
    idle(3);

    // Brightness scaling
    scale = 8'd127;
    fetch(4'd0, 24'h7F4000);
    scale = 8'd0;
    fetch(4'd0, 24'h000000);
    scale = 8'd64;
    fetch(4'd2, 24'h04080C);
    scale = 8'd255;

    // Dropped and out-of-range writes
    writePix(4'd0, 24'h010203);
    writePix(4'd1, 24'h445566);
    writePix(4'd3, 24'h778899);
    writePix(4'd9, 24'hABCDEF);
    doCommit();
    writePix(4'd1, 24'hFFFFFF);
    idle(1);
    checkOutput("t4_wr_ready", {23'd0, wr_ready}, 24'd0);
    doCommit();
    fetch(4'd0, 24'h010203);
    fetch(4'd1, 24'h445566);
    fetch(4'd9, 24'h000000);
    fetch(4'd3, 24'h778899);
    checkOutput("t4_pending", {23'd0, pending}, 24'd0);

    // Commit coinciding with frame start swaps immediately
    writePix(4'd0, 24'h5A5A5A);
    expQ.push_back('{addr: 4'd0, rgb: 24'h5A5A5A});
    applyStimulus(1'b0, 4'd0, 24'd0, 1'b1, 1'b1, 4'd0);
    idle(1);
    checkOutput("t5_pending", {23'd0, pending}, 24'd0);
    idle(2);
    fetch(4'd2, 24'h112233);

    // Reset mid-frame with a pending commit
    doCommit();
    checkOutput("t6_pending_pre", {23'd0, pending}, 24'd1);
    #2 reset = 1'b0;
    #1;
    checkOutput("t6_rgb_async", {red, green, blue}, 24'h0);
    checkOutput("t6_pending", {23'd0, pending}, 24'd0);
    checkOutput("t6_wr_ready", {23'd0, wr_ready}, 24'd1);
    idle(1);
    reset = 1'b1;
    idle(1);
    fetch(4'd0, 24'h000000);
    fetch(4'd2, 24'h000000);
    doCommit();
    fetch(4'd0, 24'h5A5A5A);

    for (int i = 0; i < 20 && expQ.size() != 0; i++) idle(1);
    if (expQ.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: got %0d outstanding, expected 0", expQ.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ws2812_framebuf.md
Name: ws2812_framebuf

Overview:
- Double-buffered pixel store that sits directly upstream of the ws2812c driver.
- Pattern logic writes 24-bit GRB/RGB pixels into a back bank. The driver reads the front bank through its address/new_address handshake.
- A commit request swaps the banks only at a frame boundary, so the strip never shows a half-written frame.
- A global brightness scale is applied on the read path.

Parameters:
- NUM_LEDS, 8, number of pixels per bank.
- ADDR_BITS, 3, width of address ports; must satisfy 2**ADDR_BITS >= NUM_LEDS.

Ports:
- clk  input  1  system clock (48 MHz in current top).
- reset  input  1  asynchronous, active-low reset.
- wr_en  input  1  write strobe for back bank, one pixel per cycle.
- wr_addr  input  ADDR_BITS  pixel index to write.
- wr_rgb  input  24  pixel data {red, green, blue}.
- wr_ready  output  1  high when writes are accepted (no commit pending, display valid logic idle).
- commit  input  1  single-cycle pulse: back bank complete, swap at next frame start.
- scale  input  8  global brightness; 255 = identity.
- address  input  ADDR_BITS  pixel index requested by driver.
- new_address  input  1  driver pulse: address changed, fetch pixel.
- red  output  8  scaled red of front-bank pixel at address.
- green  output  8  scaled green.
- blue  output  8  scaled blue.
- pending  output  1  commit accepted, swap not yet performed.

Behaviour:
- Storage:
  - Two banks of NUM_LEDS x 24 bits, inferable as RAM.
  - Bank contents are not reset.
  - front_sel selects the bank read by the driver; the other bank is the back bank.
- Reset (reset low, async):
  - red/green/blue=0, pending=0, front_sel=0, shown_valid=0, wr_ready=1.
  - Reset mid-frame forces outputs to 0 immediately; a commit pending at reset is lost.
- Write path:
  - When wr_en && wr_ready && wr_addr < NUM_LEDS, wr_rgb is written to back[wr_addr] at the clock edge.
  - wr_addr >= NUM_LEDS is ignored silently.
  - wr_en while wr_ready=0 is dropped.
  - Last write in the same cycle as commit is accepted.
- Commit:
  - commit sets pending=1 on the next edge; wr_ready = ~pending.
  - commit while pending=1 is ignored.
- Frame start = new_address && address==0.
- Swap:
  - Occurs at frame start when pending=1, or when commit=1 in that same cycle.
  - On that edge: front_sel toggles, pending clears, shown_valid sets to 1.
  - The fetch triggered by that same new_address reads the NEW front bank.
- Read path:
  - On new_address, front[address] is fetched and scaled. red/green/blue update exactly 2 clk edges after the new_address edge (RAM read + multiply register).
  - Outputs hold until the next update.
  - Driver samples no earlier than 3 cycles after new_address; WS2812 bit time is well beyond this.
- Scaling:
  - out = (c * (scale + 1)) >> 8, using a 9-bit factor and 17-bit product; bits [15:8] are taken.
  - scale=255 gives identity; scale=0 gives 0 for all c.
  - scale is sampled in the fetch cycle.
- Address >= NUM_LEDS on new_address: outputs 0.
- shown_valid=0 (no swap since reset): outputs forced to 0 regardless of RAM contents.
- new_address pulses closer than 2 cycles apart: each is processed in order, and the outputs reflect the latest request.

Test Plan:
1. Reset, then new_address for addresses 0..7 -> red/green/blue=0 for every pixel; wr_ready=1, pending=0.
2. Write addr 2=0x112233 with scale=255, pulse commit -> pending=1, wr_ready=0; next frame start swaps -> pending=0, and addr 2 reads 0x11/0x22/0x33 two cycles after its new_address; other pixels read as written or 0 if written 0.
3. Pixel 0xFF8000 at scale=127 -> red=0x7F, green=0x40, blue=0x00; at scale=0 -> all 0.
4. While pending, write addr 1=0xFFFFFF; also write wr_addr=9 when ready -> neither is stored; after the next commit and swap, addr 1 shows the previous back-bank value.
5. commit in the same cycle as new_address with address==0 -> swap on that edge; addr 0 output comes from the new bank; pending never observed high.
6. Assert reset for 1 cycle mid-frame with pending=1 -> outputs 0 asynchronously, pending=0; later frames read 0 until the next commit and swap.
